// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator bank: opcodes, flag bit positions,
// shift FSM states and small opcode classification helpers.
package acc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_CLR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9
  } acc_op_e;

  localparam int FLAG_Z     = 0;
  localparam int FLAG_C     = 1;
  localparam int FLAG_V     = 2;
  localparam int FLAG_N     = 3;
  localparam int FLAG_COUNT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  // True for the two shift opcodes.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // True for the ops that complete on the accepting edge (LOAD..CLR).
  function automatic logic is_single_op(input logic [3:0] op);
    return (op >= OP_LOAD) && (op <= OP_CLR);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational op unit: (op, a, b) -> (result, {N,V,C,Z}).
// Shift opcodes pass a through unchanged with C=0; this is the shamt=0 case,
// real shifts are stepped by the shift FSM in acc_file.
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic [FLAG_COUNT-1:0] flags
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] raw_s;
  logic                  carry_s;
  logic                  ovf_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Raw (unsaturated) result, carry/borrow and signed overflow per opcode.
  always_comb begin
    raw_s   = a;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      OP_LOAD: raw_s = b;
      OP_ADD: begin
        raw_s   = sum_s[DATA_WIDTH-1:0];
        carry_s = sum_s[DATA_WIDTH];
        ovf_s   = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        raw_s   = diff_s[DATA_WIDTH-1:0];
        carry_s = diff_s[DATA_WIDTH];
        ovf_s   = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
      end
      OP_AND:  raw_s = a & b;
      OP_OR:   raw_s = a | b;
      OP_XOR:  raw_s = a ^ b;
      OP_CLR:  raw_s = {DATA_WIDTH{1'b0}};
      default: raw_s = a;
    endcase
  end

  // Optional clamp on overflow (direction follows the sign of a), then flags.
  // C keeps the raw carry even when the result is clamped.
  always_comb begin
    if ((SATURATE != 0) && ovf_s) begin
      result = a[MSB] ? SAT_MIN : SAT_MAX;
    end else begin
      result = raw_s;
    end
    flags         = {FLAG_COUNT{1'b0}};
    flags[FLAG_Z] = (result == {DATA_WIDTH{1'b0}});
    flags[FLAG_N] = result[MSB];
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

endmodule

// File: rtl/acc_file.sv
// Accumulator bank: ACC_COUNT registers with per-register {N,V,C,Z} flags,
// single-cycle ops through acc_alu and a bit-serial shift FSM that stalls
// op_ready while a shift is in progress.
module acc_file
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_COUNT   = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int SHAMT_WIDTH = 3,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [3:0]             op,
  input  logic [SEL_WIDTH-1:0]   sel,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  data_alu,
  input  logic [SEL_WIDTH-1:0]   rd_sel,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [FLAG_COUNT-1:0]  flags_out,
  output logic                   busy
);

  localparam logic [SEL_WIDTH:0]   ACC_LIMIT = (SEL_WIDTH+1)'(ACC_COUNT);
  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1'b1);

  logic [DATA_WIDTH-1:0]  acc_r   [ACC_COUNT];
  logic [FLAG_COUNT-1:0]  flags_r [ACC_COUNT];

  shift_state_e           state_r;
  shift_state_e           state_next_s;
  logic [SHAMT_WIDTH-1:0] shift_cnt_r;
  logic [DATA_WIDTH-1:0]  shift_val_r;
  logic [SEL_WIDTH-1:0]   shift_sel_r;
  logic                   shift_right_r;
  logic [DATA_WIDTH-1:0]  shift_next_s;
  logic                   shift_bit_s;

  logic                   fire_s;
  logic                   sel_ok_s;
  logic                   start_shift_s;
  logic                   last_step_s;
  logic                   single_s;
  logic [DATA_WIDTH-1:0]  alu_a_s;
  logic [DATA_WIDTH-1:0]  alu_res_s;
  logic [FLAG_COUNT-1:0]  alu_flags_s;

  logic                   wr_en_s;
  logic [SEL_WIDTH-1:0]   wr_sel_s;
  logic [DATA_WIDTH-1:0]  wr_val_s;
  logic [FLAG_COUNT-1:0]  wr_flags_s;

  assign op_ready = (state_r == ST_IDLE);
  assign busy     = (state_r == ST_SHIFT);
  assign fire_s   = op_valid & op_ready;
  assign sel_ok_s = ({1'b0, sel} < ACC_LIMIT);

  // Shifts with shamt=0 behave as single-cycle ops; out-of-range targets do nothing.
  assign start_shift_s = fire_s & sel_ok_s & is_shift_op(op) &
                         (shamt != {SHAMT_WIDTH{1'b0}});
  assign single_s      = is_single_op(op) |
                         (is_shift_op(op) & (shamt == {SHAMT_WIDTH{1'b0}}));
  assign last_step_s   = (state_r == ST_SHIFT) && (shift_cnt_r == CNT_ONE);

  // Operand A for the op unit: the addressed accumulator, zero when out of range.
  always_comb begin
    if (sel_ok_s) begin
      alu_a_s = acc_r[sel];
    end else begin
      alu_a_s = {DATA_WIDTH{1'b0}};
    end
  end

  acc_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_alu (
    .op     (op),
    .a      (alu_a_s),
    .b      (data_alu),
    .result (alu_res_s),
    .flags  (alu_flags_s)
  );

  // One-bit shift step of the working value; SHR is logical.
  always_comb begin
    if (shift_right_r) begin
      shift_next_s = {1'b0, shift_val_r[DATA_WIDTH-1:1]};
      shift_bit_s  = shift_val_r[0];
    end else begin
      shift_next_s = {shift_val_r[DATA_WIDTH-2:0], 1'b0};
      shift_bit_s  = shift_val_r[DATA_WIDTH-1];
    end
  end

  // Register-file write port: either the final shift step or an accepted single-cycle op.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_sel_s   = sel;
    wr_val_s   = alu_res_s;
    wr_flags_s = alu_flags_s;
    if (last_step_s) begin
      wr_en_s            = 1'b1;
      wr_sel_s           = shift_sel_r;
      wr_val_s           = shift_next_s;
      wr_flags_s         = {FLAG_COUNT{1'b0}};
      wr_flags_s[FLAG_Z] = (shift_next_s == {DATA_WIDTH{1'b0}});
      wr_flags_s[FLAG_N] = shift_next_s[DATA_WIDTH-1];
      wr_flags_s[FLAG_C] = shift_bit_s;
    end else if (fire_s && sel_ok_s && single_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Shift FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Shift FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_shift_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shift working registers: captured on acceptance, stepped once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt_r   <= {SHAMT_WIDTH{1'b0}};
      shift_val_r   <= {DATA_WIDTH{1'b0}};
      shift_sel_r   <= {SEL_WIDTH{1'b0}};
      shift_right_r <= 1'b0;
    end else if (start_shift_s) begin
      shift_cnt_r   <= shamt;
      shift_val_r   <= alu_a_s;
      shift_sel_r   <= sel;
      shift_right_r <= (op == OP_SHR);
    end else if (state_r == ST_SHIFT) begin
      shift_cnt_r   <= shift_cnt_r - CNT_ONE;
      shift_val_r   <= shift_next_s;
    end
  end

  // Accumulator and flag storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACC_COUNT; i++) begin
        acc_r[i]   <= {DATA_WIDTH{1'b0}};
        flags_r[i] <= {FLAG_COUNT{1'b0}};
      end
    end else if (wr_en_s) begin
      acc_r[wr_sel_s]   <= wr_val_s;
      flags_r[wr_sel_s] <= wr_flags_s;
    end
  end

  // Read port: registered state only, so a same-cycle write is not visible yet.
  always_comb begin
    if ({1'b0, rd_sel} < ACC_LIMIT) begin
      data_out  = acc_r[rd_sel];
      flags_out = flags_r[rd_sel];
    end else begin
      data_out  = {DATA_WIDTH{1'b0}};
      flags_out = {FLAG_COUNT{1'b0}};
    end
  end

endmodule

// File: tb/tb_acc_file.sv
// Bench for acc_file: a wrapping and a saturating instance share one stimulus
// stream; an arithmetic reference model predicts every accumulator and flag set.
module tb_acc_file;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [3:0] op = 4'd0;
  logic [1:0] sel = 2'd0;
  logic [2:0] shamt = 3'd0;
  logic [7:0] data_alu = 8'd0;
  logic [1:0] rd_sel = 2'd0;

  logic       ready_wrap, busy_wrap, ready_sat, busy_sat;
  logic [7:0] dout_wrap, dout_sat;
  logic [3:0] flg_wrap, flg_sat;

  int tests_run = 0;
  int tests_failed = 0;
  int m_acc [2][4];
  int m_flg [2][4];

  acc_file #(.DATA_WIDTH(8), .ACC_COUNT(4), .SEL_WIDTH(2), .SHAMT_WIDTH(3), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_wrap), .op(op), .sel(sel),
    .shamt(shamt), .data_alu(data_alu), .rd_sel(rd_sel), .data_out(dout_wrap),
    .flags_out(flg_wrap), .busy(busy_wrap));

  acc_file #(.DATA_WIDTH(8), .ACC_COUNT(4), .SEL_WIDTH(2), .SHAMT_WIDTH(3), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_sat), .op(op), .sel(sel),
    .shamt(shamt), .data_alu(data_alu), .rd_sel(rd_sel), .data_out(dout_sat),
    .flags_out(flg_sat), .busy(busy_sat));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [7:0] got_data(input int k);
    return (k == 0) ? dout_wrap : dout_sat;
  endfunction

  function automatic logic [3:0] got_flags(input int k);
    return (k == 0) ? flg_wrap : flg_sat;
  endfunction

  function automatic logic got_ready(input int k);
    return (k == 0) ? ready_wrap : ready_sat;
  endfunction

  function automatic logic got_busy(input int k);
    return (k == 0) ? busy_wrap : busy_sat;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        m_acc[k][i] = 0;
        m_flg[k][i] = 0;
      end
  endtask

  // k=0 wraps, k=1 saturates. Flags packed as {N,V,C,Z}.
  task automatic model_op(input int o, input int s, input int sh, input int d);
    int a, r, c, v, sa, sb, sr;
    if (o < 1 || o > 9) return;
    for (int k = 0; k < 2; k++) begin
      a = m_acc[k][s];
      r = a; c = 0; v = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (d >= 128) ? d - 256 : d;
      case (o)
        1: r = d;
        2: begin
          r = (a + d) % 256; c = (a + d > 255) ? 1 : 0;
          sr = sa + sb; v = (sr > 127 || sr < -128) ? 1 : 0;
          if (k == 1 && v == 1) r = (sr > 127) ? 127 : 128;
        end
        3: begin
          r = (a - d + 256) % 256; c = (a < d) ? 1 : 0;
          sr = sa - sb; v = (sr > 127 || sr < -128) ? 1 : 0;
          if (k == 1 && v == 1) r = (sr > 127) ? 127 : 128;
        end
        4: r = a & d;
        5: r = a | d;
        6: r = a ^ d;
        7: r = 0;
        8: begin r = (a << sh) % 256; c = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1); end
        9: begin r = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
        default: r = a;
      endcase
      m_acc[k][s] = r;
      m_flg[k][s] = ((r >= 128) ? 8 : 0) + v * 4 + c * 2 + ((r == 0) ? 1 : 0);
    end
  endtask

  task automatic drive(input int o, input int s, input int sh, input int d);
    op_valid = 1'b1;
    op       = o[3:0];
    sel      = s[1:0];
    shamt    = sh[2:0];
    data_alu = d[7:0];
  endtask

  // Issue one op, update the model, then wait (bounded) until both DUTs are ready.
  task automatic run_op(input int o, input int s, input int sh, input int d, output int cycles);
    drive(o, s, sh, d);
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_op(o, s, sh, d);
    cycles = 0;
    while (!(ready_wrap === 1'b1 && ready_sat === 1'b1) && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic read_acc(input int i);
    rd_sel = i[1:0];
    #1;
  endtask

  task automatic test_reset();
    int cyc;
    for (int n = 0; n < 3; n++) run_op(1, n, 0, int'($urandom_range(1, 255)), cyc);
    drive(8, 0, 6, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_ready(k) !== 1'b1 || got_busy(k) !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset ready/busy dut%0d: got %b/%b required 1/0", k, got_ready(k), got_busy(k));
      end
    end
    for (int i = 0; i < 4; i++) begin
      read_acc(i);
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (got_data(k) !== 8'h00 || got_flags(k) !== 4'h0) begin
          tests_failed++;
          $display("FAIL reset acc%0d dut%0d: got %h/%b required 00/0000", i, k, got_data(k), got_flags(k));
        end
      end
    end
  endtask

  task automatic test_load_add();
    int cyc;
    run_op(1, 1, 0, 8'h3C, cyc);
    run_op(1, 0, 0, 8'hFF, cyc);
    run_op(2, 0, 0, 8'h01, cyc);
    tests_run++;
    if (cyc !== 0) begin
      tests_failed++;
      $display("FAIL add latency: got %0d required 0", cyc);
    end
    read_acc(0);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_data(k) !== 8'h00 || got_flags(k) !== 4'b0011) begin
        tests_failed++;
        $display("FAIL add wrap a0 dut%0d: got %h/%b required 00/0011", k, got_data(k), got_flags(k));
      end
    end
    read_acc(1);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_data(k) !== 8'h3C || got_flags(k) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL add a1 untouched dut%0d: got %h/%b required 3c/0000", k, got_data(k), got_flags(k));
      end
    end
  endtask

  task automatic test_saturate();
    int cyc;
    run_op(1, 3, 0, 8'h7F, cyc);
    run_op(2, 3, 0, 8'h01, cyc);
    read_acc(3);
    tests_run++;
    if (dout_wrap !== 8'h80 || flg_wrap !== 4'b1100) begin
      tests_failed++;
      $display("FAIL add overflow wrap: got %h/%b required 80/1100", dout_wrap, flg_wrap);
    end
    tests_run++;
    if (dout_sat !== 8'h7F || flg_sat !== 4'b0100) begin
      tests_failed++;
      $display("FAIL add overflow sat: got %h/%b required 7f/0100", dout_sat, flg_sat);
    end
    run_op(1, 3, 0, 8'h80, cyc);
    run_op(3, 3, 0, 8'h01, cyc);
    read_acc(3);
    tests_run++;
    if (dout_wrap !== 8'h7F || flg_wrap !== 4'b0100) begin
      tests_failed++;
      $display("FAIL sub overflow wrap: got %h/%b required 7f/0100", dout_wrap, flg_wrap);
    end
    tests_run++;
    if (dout_sat !== 8'h80 || flg_sat !== 4'b1100) begin
      tests_failed++;
      $display("FAIL sub overflow sat: got %h/%b required 80/1100", dout_sat, flg_sat);
    end
  endtask

  task automatic test_shift();
    int cyc;
    int busy_cycles;
    run_op(1, 0, 0, 8'h5A, cyc);
    run_op(1, 2, 0, 8'h81, cyc);
    rd_sel = 2'd2;
    drive(8, 2, 3, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_op(8, 2, 3, 0);
    busy_cycles = 0;
    while (ready_wrap !== 1'b1 && busy_cycles < 20) begin
      tests_run++;
      if (dout_wrap !== 8'h81 || busy_wrap !== 1'b1 || ready_sat !== 1'b0) begin
        tests_failed++;
        $display("FAIL shift in flight: got data %h busy %b required 81/1", dout_wrap, busy_wrap);
      end
      if (busy_cycles == 0) drive(1, 0, 0, 8'h33);
      else op_valid = 1'b0;
      @(posedge clk); #1;
      busy_cycles++;
    end
    op_valid = 1'b0;
    tests_run++;
    if (busy_cycles !== 3) begin
      tests_failed++;
      $display("FAIL shl busy length: got %0d required 3", busy_cycles);
    end
    read_acc(2);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_data(k) !== 8'h08 || got_flags(k) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL shl result dut%0d: got %h/%b required 08/0000", k, got_data(k), got_flags(k));
      end
    end
    read_acc(0);
    tests_run++;
    if (dout_wrap !== 8'h5A) begin
      tests_failed++;
      $display("FAIL op during busy executed: got a0=%h required 5a", dout_wrap);
    end
    // shamt=0 after a borrow: value kept, C cleared, N/Z refreshed
    run_op(1, 2, 0, 8'h01, cyc);
    run_op(3, 2, 0, 8'h02, cyc);
    run_op(8, 2, 0, 0, cyc);
    tests_run++;
    if (cyc !== 0) begin
      tests_failed++;
      $display("FAIL shamt0 latency: got %0d required 0", cyc);
    end
    read_acc(2);
    tests_run++;
    if (dout_wrap !== 8'hFF || flg_wrap !== 4'b1000) begin
      tests_failed++;
      $display("FAIL shamt0 result: got %h/%b required ff/1000", dout_wrap, flg_wrap);
    end
  endtask

  task automatic test_shift_reset();
    int cyc;
    run_op(1, 2, 0, 8'hF0, cyc);
    drive(9, 2, 5, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    tests_run++;
    if (ready_wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL shr start: got op_ready %b required 0", ready_wrap);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_ready(k) !== 1'b1) begin
        tests_failed++;
        $display("FAIL abort ready dut%0d: got %b required 1", k, got_ready(k));
      end
    end
    read_acc(2);
    tests_run++;
    if (dout_wrap !== 8'h00 || flg_wrap !== 4'h0) begin
      tests_failed++;
      $display("FAIL abort a2: got %h/%b required 00/0000", dout_wrap, flg_wrap);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(1, 1, 0, 8'h77, cyc);
    rd_sel = 2'd1;
    drive(1, 1, 0, 8'h10);
    #1;
    tests_run++;
    if (dout_wrap !== 8'h77) begin
      tests_failed++;
      $display("FAIL b2b load-cycle read: got %h required 77", dout_wrap);
    end
    @(posedge clk); #1;
    model_op(1, 1, 0, 8'h10);
    drive(3, 1, 0, 8'h20);
    #1;
    tests_run++;
    if (dout_wrap !== 8'h10) begin
      tests_failed++;
      $display("FAIL b2b sub-cycle read: got %h required 10", dout_wrap);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_op(3, 1, 0, 8'h20);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (got_data(k) !== 8'hF0 || got_flags(k) !== 4'b1010) begin
        tests_failed++;
        $display("FAIL b2b sub result dut%0d: got %h/%b required f0/1010", k, got_data(k), got_flags(k));
      end
    end
  endtask

  task automatic test_random();
    int o, s, sh, d, cyc, exp_cyc;
    for (int n = 0; n < 150; n++) begin
      o  = int'($urandom_range(0, 15));
      s  = int'($urandom_range(0, 3));
      sh = int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, 255));
      run_op(o, s, sh, d, cyc);
      exp_cyc = ((o == 8 || o == 9) && sh != 0) ? sh : 0;
      tests_run++;
      if (cyc !== exp_cyc) begin
        tests_failed++;
        $display("FAIL rand latency op%0d sh%0d: got %0d required %0d", o, sh, cyc, exp_cyc);
      end
      for (int i = 0; i < 4; i++) begin
        read_acc(i);
        for (int k = 0; k < 2; k++) begin
          tests_run++;
          if (got_data(k) !== m_acc[k][i][7:0] || got_flags(k) !== m_flg[k][i][3:0]) begin
            tests_failed++;
            $display("FAIL rand op%0d acc%0d dut%0d: got %h/%b required %h/%b", o, i, k,
                     got_data(k), got_flags(k), m_acc[k][i][7:0], m_flg[k][i][3:0]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_load_add();
    test_saturate();
    test_shift();
    test_shift_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
